// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline sequencing logic: FSM states,
// register-address and counter widths, and the packed control-output bundle.
`timescale 1ns/1ps
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int STALL_CNT_W = 32;
  localparam int FLUSH_CNT_W = 3;   // holds FLUSH_EXTRA up to 7
  localparam int WAIT_CNT_W  = 16;  // holds WAIT_TIMEOUT up to 65535

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    BFLUSH  = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_exe_write;
    logic ctrl_flush;
    logic if_flush;
  } ctrl_out_t;

  // Field order: pc_write, if_id_write, id_exe_write, ctrl_flush, if_flush.
  localparam ctrl_out_t CTRL_RUN      = 5'b111_00;
  localparam ctrl_out_t CTRL_FREEZE   = 5'b000_00;
  localparam ctrl_out_t CTRL_BRANCH   = 5'b111_11;
  localparam ctrl_out_t CTRL_LOAD_USE = 5'b001_10;
  localparam ctrl_out_t CTRL_RESET    = 5'b000_11;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in EXE whose destination is read
// by the instruction in decode. x0 never creates a dependency.
`timescale 1ns/1ps
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  output logic                  lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit = id_use_rs2 && (id_rs2_addr == ex_rd_addr);
  assign lu      = ex_mem_read && (ex_rd_addr != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flushes and
// data-memory freezes with a sticky watchdog, plus a saturating stall counter.
`timescale 1ns/1ps
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_EXTRA  = 1,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_mem_read,
  input  logic [REG_ADDR_W-1:0]  ex_rd_addr,
  input  logic [REG_ADDR_W-1:0]  id_rs1_addr,
  input  logic [REG_ADDR_W-1:0]  id_rs2_addr,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_exe_write,
  output logic                   ctrl_flush,
  output logic                   if_flush,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   mem_timeout
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_EXTRA);
  localparam logic [WAIT_CNT_W-1:0]  WAIT_MAX   = WAIT_CNT_W'(WAIT_TIMEOUT);

  state_e                 state_q, state_d;
  state_e                 ret_state_q, ret_state_d;
  state_e                 eff_state;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   lu;
  logic                   ms;
  ctrl_out_t              ctrl;

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd_addr  (ex_rd_addr),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .lu          (lu)
  );

  assign ms = mem_req & ~mem_ready;

  // NOTE: every variable written here gets a default first, so no latches are inferred.
  always_comb begin
    state_d     = state_q;
    ret_state_d = ret_state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    ctrl        = CTRL_RUN;

    // Release from a freeze applies the interrupted state's rules in the same cycle.
    eff_state = (state_q == MEMWAIT && mem_ready) ? ret_state_q : state_q;

    unique case (eff_state)
      MEMWAIT: begin
        ctrl       = CTRL_FREEZE;
        wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_CNT_W'(1);
      end
      BFLUSH: begin
        if (ms) begin
          // Flush count is left untouched so the flush resumes after the freeze.
          ctrl        = CTRL_FREEZE;
          state_d     = MEMWAIT;
          ret_state_d = BFLUSH;
          wait_cnt_d  = WAIT_CNT_W'(1);
        end else begin
          ctrl        = CTRL_BRANCH;
          flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
          state_d     = (flush_cnt_q == FLUSH_CNT_W'(1)) ? RUN : BFLUSH;
        end
      end
      default: begin
        state_d = RUN;
        if (ms) begin
          ctrl        = CTRL_FREEZE;
          state_d     = MEMWAIT;
          ret_state_d = RUN;
          wait_cnt_d  = WAIT_CNT_W'(1);
        end else if (ex_branch_taken) begin
          ctrl = CTRL_BRANCH;
          if (FLUSH_EXTRA > 0) begin
            state_d     = BFLUSH;
            flush_cnt_d = FLUSH_INIT;
          end
        end else if (lu) begin
          ctrl = CTRL_LOAD_USE;
        end
      end
    endcase

    if (wait_cnt_d == WAIT_MAX) timeout_d = 1'b1;

    // Reset forces the safe output pattern immediately, independent of the clock.
    if (!rst) ctrl = CTRL_RESET;

    if (!ctrl.pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      ret_state_q <= RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign id_exe_write = ctrl.id_exe_write;
  assign ctrl_flush   = ctrl.ctrl_flush;
  assign if_flush     = ctrl.if_flush;
  assign stall_cnt    = stall_cnt_q;
  assign mem_timeout  = timeout_q;

endmodule
